// File: rtl/mult_div_unit_if.sv
// Execute-stage multiply/divide bus: instruction-side request fields and the HI/LO/status view.
//   master (pipeline): drives start, ALUOp, ALUFunction, rs_data, rt_data.
//                      Observes busy, stall_req, done, div_by_zero, hi, lo, result.
//   slave (mult_div_unit): the mirror image of master.
interface mult_div_unit_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ALUOP_WIDTH = 3
);
  logic                   start;
  logic [ALUOP_WIDTH-1:0] ALUOp;
  logic [5:0]             ALUFunction;
  logic [DATA_WIDTH-1:0]  rs_data;
  logic [DATA_WIDTH-1:0]  rt_data;
  logic                   busy;
  logic                   stall_req;
  logic                   done;
  logic                   div_by_zero;
  logic [DATA_WIDTH-1:0]  hi;
  logic [DATA_WIDTH-1:0]  lo;
  logic [DATA_WIDTH-1:0]  result;

  modport master (
    output start, ALUOp, ALUFunction, rs_data, rt_data,
    input  busy, stall_req, done, div_by_zero, hi, lo, result
  );

  modport slave (
    input  start, ALUOp, ALUFunction, rs_data, rt_data,
    output busy, stall_req, done, div_by_zero, hi, lo, result
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, one iteration per clock.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - mult_div_unit_if.slave. Decodes ALUOp/ALUFunction on start and reports
//           busy, stall_req, done, div_by_zero and hi/lo. result carries MFHI/MFLO read data.
// Operation: signed ops are run on magnitudes; the signs are reapplied in a final FIX cycle.
// HI/LO are written only at the end, so partial results are never visible.
module mult_div_unit #(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            ALUOP_WIDTH  = 3,
  parameter logic [ALUOP_WIDTH-1:0] R_TYPE_ALUOP = ALUOP_WIDTH'(3'b111)
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMthi  = 6'b010001;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMtlo  = 6'b010011;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Multiply: product accumulator, multiplier shifted out from the bottom.
  // Divide: {partial remainder, dividend/quotient shift register}.
  logic [2*W-1:0]  acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [W-1:0]    b_q, b_d;
  logic            is_div_q, is_div_d;
  // neg_lo: negate product/quotient; neg_hi: negate remainder.
  logic            neg_lo_q, neg_lo_d;
  logic            neg_hi_q, neg_hi_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic r_type;
  logic dec_mult, dec_multu, dec_div, dec_divu;
  logic dec_mfhi, dec_mthi, dec_mflo, dec_mtlo;
  logic dec_muldiv, dec_any, dec_divide, dec_signed;
  logic busy, accept;

  assign r_type     = (bus.ALUOp == R_TYPE_ALUOP);
  assign dec_mult   = r_type && (bus.ALUFunction == FnMult);
  assign dec_multu  = r_type && (bus.ALUFunction == FnMultu);
  assign dec_div    = r_type && (bus.ALUFunction == FnDiv);
  assign dec_divu   = r_type && (bus.ALUFunction == FnDivu);
  assign dec_mfhi   = r_type && (bus.ALUFunction == FnMfhi);
  assign dec_mthi   = r_type && (bus.ALUFunction == FnMthi);
  assign dec_mflo   = r_type && (bus.ALUFunction == FnMflo);
  assign dec_mtlo   = r_type && (bus.ALUFunction == FnMtlo);
  assign dec_muldiv = dec_mult | dec_multu | dec_div | dec_divu;
  assign dec_any    = dec_muldiv | dec_mfhi | dec_mthi | dec_mflo | dec_mtlo;
  assign dec_divide = dec_div | dec_divu;
  assign dec_signed = dec_mult | dec_div;

  assign busy   = (state_q != StIdle);
  assign accept = bus.start & ~busy;

  // ---------------------------------------------------------------------------
  // Operand magnitudes and result signs (unsigned ops never negate)
  // ---------------------------------------------------------------------------
  logic         rs_neg, rt_neg;
  logic [W-1:0] rs_mag, rt_mag;

  assign rs_neg = dec_signed & bus.rs_data[W-1];
  assign rt_neg = dec_signed & bus.rt_data[W-1];
  // The most-negative value maps onto itself, which is the correct unsigned magnitude.
  assign rs_mag = rs_neg ? (~bus.rs_data + W'(1)) : bus.rs_data;
  assign rt_mag = rt_neg ? (~bus.rt_data + W'(1)) : bus.rt_data;

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;

  // Shift-add: conditionally add the multiplicand to the upper half, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W + 1){1'b0}});
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Restoring divide: bring down the next dividend bit and trial-subtract the divisor.
  // Remainder < divisor, so the shifted value fits in W+1 bits and the borrow is diff[W].
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[W];
  assign div_next  = div_ge ? {div_diff[W-1:0], acc_q[W-2:0], 1'b1}
                            : {div_shift[W-1:0], acc_q[W-2:0], 1'b0};

  // ---------------------------------------------------------------------------
  // Sign correction applied in FIX
  // ---------------------------------------------------------------------------
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_lo_q ? (~acc_q + (2 * W)'(1)) : acc_q;
  assign quo_fix  = neg_lo_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
  assign rem_fix  = neg_hi_q ? (~acc_q[2*W-1:W] + W'(1)) : acc_q[2*W-1:W];

  // ---------------------------------------------------------------------------
  // FSM next state / register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept && dec_muldiv) begin
          if (dec_divide && (bus.rt_data == '0)) begin
            // Divide by zero: flag it immediately and leave HI/LO alone.
            done_d = 1'b1;
            dbz_d  = 1'b1;
          end else begin
            state_d  = StRun;
            cnt_d    = '0;
            is_div_d = dec_divide;
            neg_lo_d = rs_neg ^ rt_neg;
            neg_hi_d = dec_divide ? rs_neg : (rs_neg ^ rt_neg);
            if (dec_divide) begin
              acc_d = {{W{1'b0}}, rs_mag};
              b_d   = rt_mag;
            end else begin
              acc_d = {{W{1'b0}}, rt_mag};
              b_d   = rs_mag;
            end
          end
        end
        if (accept && dec_mthi) hi_d = bus.rs_data;
        if (accept && dec_mtlo) lo_d = bus.rs_data;
      end

      StRun: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) state_d = StFix;
      end

      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [W-1:0] result;

  always_comb begin
    result = '0;
    if (accept && dec_mfhi) result = hi_q;
    else if (accept && dec_mflo) result = lo_q;
  end

  assign bus.busy        = busy;
  assign bus.stall_req   = bus.start & busy & dec_any;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.result      = result;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers; sits beside the single-cycle ALU in the execute stage.
- Decodes ALUOp plus the R-type function field itself, for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Iterates one bit per cycle and requests a pipeline stall when HI/LO are accessed before a result is ready.

Parameters:
- DATA_WIDTH, 32: operand, HI and LO width (W); any even value ≥ 8.
- ALUOP_WIDTH, 3: width of ALUOp.
- R_TYPE_ALUOP, 3'b111: ALUOp value that enables function-field decode.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  instruction-valid strobe; sampled with ALUOp/ALUFunction.
- ALUOp  input  ALUOP_WIDTH  operation class from control unit.
- ALUFunction  input  6  instruction function field.
- rs_data  input  DATA_WIDTH  dividend / multiplicand / MTHI-MTLO source.
- rt_data  input  DATA_WIDTH  divisor / multiplier.
- busy  output  1  iteration in progress.
- stall_req  output  1  combinational; pipeline must hold the current instruction.
- done  output  1  one-cycle pulse when HI/LO have been updated by MULT/DIV.
- div_by_zero  output  1  pulses with done when the divisor was zero.
- hi  output  DATA_WIDTH  HI register.
- lo  output  DATA_WIDTH  LO register.
- result  output  DATA_WIDTH  combinational MFHI/MFLO read data; 0 otherwise.

Behaviour:
- Decode is active only when ALUOp==R_TYPE_ALUOP. Function codes:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - Any other code is ignored: no state change, no stall.
- Reset (async, any state, including mid-operation): state IDLE; busy, done, div_by_zero, hi, lo and the iteration counter all 0.
- FSM states: IDLE, RUN, FIX.
  - IDLE->RUN on start & MULT/MULTU/DIV/DIVU & divisor≠0 (divisor check applies to DIV/DIVU only). Latch |rs|, |rt|, the op, and the result signs (signed ops only). Counter=0.
  - RUN: one iteration per cycle. Multiply is shift-add into a 2W accumulator; divide is restoring, one quotient bit per cycle. After W cycles go to FIX.
  - FIX->IDLE: apply sign correction and write hi/lo at the FIX->IDLE edge. done=1 in the following cycle.
- Latency: start accepted in cycle 0 -> busy=1 in cycles 1..W+1 -> hi/lo valid and done=1 in cycle W+2. For W=32, done is in cycle 34.
- Multiply: {hi,lo} = full 2W-bit product. MULT uses two's-complement operands, MULTU unsigned.
- Divide:
  - lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - Signed overflow (most-negative / -1) gives lo=most-negative, hi=0, no flag.
- Divide by zero (DIV/DIVU with rt==0): no RUN. done=1 and div_by_zero=1 in cycle 1; busy stays 0; hi/lo unchanged.
- MTHI/MTLO: on start while not busy, write rs_data to hi/lo at the clock edge.
- MFHI/MFLO: result = hi/lo combinationally when decoded with start and not busy.
- stall_req = start & busy & (any decoded MULT/DIV/MF/MT op). Stalled instructions have no effect and are re-presented by the pipeline.
- start with a MULT/DIV op in the same cycle that done=1: accepted normally (state is IDLE).
- hi/lo hold their old values throughout RUN/FIX; partial results are never visible.
- done and div_by_zero are single-cycle pulses and are never asserted together with busy.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF at cycle 0 -> busy cycles 1-33; done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=100 rt=0 with hi=0x11, lo=0x22 -> cycle 1: done=1, div_by_zero=1, busy=0; hi/lo stay 0x11/0x22. DIVU 100/7 -> lo=14, hi=2.
- MFLO presented at cycle 5 of a MULT -> stall_req=1 through cycle 33. Second MULT at cycle 5 -> stall_req=1 and operands not relatched. Cycle 34: MFLO gives stall_req=0, result=lo.
- MTHI rs=0xA5A5A5A5, then MFHI -> hi=0xA5A5A5A5, result=0xA5A5A5A5. ALUOp=3'b000 with funct 011000 -> no busy, hi/lo unchanged.
- reset pulsed mid-cycle at cycle 10 of a DIV -> busy, hi, lo=0 immediately (before the next edge). A new MULTU 3*5 then gives lo=15, hi=0 at cycle W+2 after its start.
